inst_fetch_unit: RTL

- Instruction-fetch front end that sits directly upstream of the CPU decode stage.
- Acts as the Wishbone-style bus master for instruction reads: issues sequential word fetches, buffers the returned words with their PCs in a small prefetch FIFO, and hands them to the CPU over a valid/ready interface.
- Accepts PC redirects (branch, skip, interrupt entry) from the CPU; a redirect flushes the FIFO and any in-flight fetch.

---
 rtl/inst_fetch_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction-fetch front end in front of the CPU decode stage. Acts as the
// bus master for sequential word fetches, buffers each returned word with its
// PC in a small prefetch FIFO and hands them to the CPU over valid/ready.
// A PC redirect from the CPU flushes the FIFO and any in-flight fetch.
//
// Parameters:
//   DEPTH     prefetch FIFO entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports:
//   clk             system clock, all state on the rising edge
//   W_RST           asynchronous active-low reset
//   W_ADDR          bus address of the current fetch (registered)
//   W_STB           bus request strobe (doubles as cycle)
//   W_DAT_I         bus read data, valid with W_ACK
//   W_ACK           bus acknowledge, one pulse per request
//   redirect_valid  load a new fetch PC this cycle
//   redirect_pc     new fetch PC, bits [1:0] ignored
//   inst_valid      head FIFO entry is available
//   inst_data       head instruction word
//   inst_pc         address the head word was fetched from
//   inst_ready      CPU consumes the head entry when inst_valid is high
// ----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        W_RST,
    output logic [31:0] W_ADDR,
    output logic        W_STB,
    input  logic [31:0] W_DAT_I,
    input  logic        W_ACK,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // IDLE: no bus request. REQ: fetch whose data will be kept.
    // DRAIN: fetch made stale by a redirect; its data is thrown away.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [31:0]    fetch_pc;
    logic [31:0]    fetch_pc_next;
    logic [31:0]    addr_q;

    logic [31:0]    fifo_data [DEPTH];
    logic [31:0]    fifo_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic push;
    logic pop;

    // A redirect discards both the acked word and the CPU's pop this cycle.
    assign push       = (state == REQ) && W_ACK && !redirect_valid;
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every register is written with <= so all flops sample the same
    // pre-edge values; blocking assignments here would create order races.
    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so that no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (redirect_valid || (count < FULL_COUNT)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    // A pending request is never withdrawn, so an un-acked
                    // fetch must finish on the bus before the new PC goes out.
                    state_next = W_ACK ? REQ : DRAIN;
                end else if (W_ACK && (count_next == FULL_COUNT)) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (W_ACK) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        W_STB = (state != IDLE);
    end

    // ------------------------------------------------------------------
    // Fetch PC and bus address
    // ------------------------------------------------------------------
    always_comb begin
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end else begin
            fetch_pc_next = fetch_pc;
        end
    end

    // The bus address only moves when no request is outstanding (IDLE) or
    // the outstanding one completes, keeping W_ADDR stable for a request.
    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_next;
            if ((state == IDLE) || W_ACK) begin
                addr_q <= fetch_pc_next;
            end
        end
    end

    assign W_ADDR = addr_q;

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and the head outputs are forced to zero when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= W_DAT_I;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'd0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'd0;

endmodule
